registro_universal_n: RTL and testbench
=======================================

# registro_universal_n

Parametrised universal register, successor to the fixed 4-bit enable register `Registro4Bit`. It holds an `ANCHO`-bit word and, under a 3-bit mode select, performs hold, parallel load, logical shift, rotate and up/down count, with a registered carry/shift-out flag and a zero flag. It is the general-purpose storage and sequencing element for lab datapaths that previously instantiated several single-purpose 4-bit registers.

## Interface
- `ANCHO`, 4, data width in bits; legal range is 2 to 32.
- `VALOR_REINICIO`, `{ANCHO{1'b0}}`, value loaded into `Salida` on reset.

Ports:
- `Reloj`  input  1  clock; all state changes on the rising edge.
- `Reiniciar`  input  1  synchronous, active-low reset. Sampled at the rising edge of `Reloj`.
- `Habilitar`  input  1  operation enable; when 0, all state holds.
- `Modo`  input  3  operation select (see Operation).
- `Dato`  input  ANCHO  parallel load value.
- `EntSerie`  input  1  serial input bit for shift modes.
- `Salida`  output  ANCHO  registered register contents.
- `Acarreo`  output  1  registered carry, borrow or shift-out flag.
- `Cero`  output  1  combinational; 1 when `Salida == 0`.

## Operation
- Priority order at each rising edge:
  1. `Reiniciar == 0`: `Salida <= VALOR_REINICIO`, `Acarreo <= 0`.
  2. Otherwise, `Habilitar == 0`: `Salida` and `Acarreo` hold.
  3. Otherwise, execute `Modo`.
- `Modo` encoding (S = `Salida`, N = `ANCHO`):
  - `000` hold: S unchanged, `Acarreo <= 0`.
  - `001` load: `S <= Dato`, `Acarreo <= 0`.
  - `010` shift left: `S <= {S[N-2:0], EntSerie}`, `Acarreo <= S[N-1]`.
  - `011` shift right: `S <= {EntSerie, S[N-1:1]}`, `Acarreo <= S[0]`.
  - `100` rotate left: `S <= {S[N-2:0], S[N-1]}`, `Acarreo <= S[N-1]`.
  - `101` rotate right: `S <= {S[0], S[N-1:1]}`, `Acarreo <= S[0]`.
  - `110` count up: `S <= S + 1` modulo 2^N. `Acarreo <= 1` only when S was all-ones (wrap to 0), else 0.
  - `111` count down: `S <= S - 1` modulo 2^N. `Acarreo <= 1` only when S was 0 (wrap to all-ones), else 0.
- Arithmetic is unsigned and N bits wide. The carry is the (N+1)th bit of the sum, or the borrow of the difference.
- `Cero` is derived from registered `Salida` only, so it is glitch-free relative to inputs.
- No internal FSM beyond the data register. Mode changes take effect on the very next enabled edge, with no settling cycle.

## Timing
- Latency: one `Reloj` edge from sampled inputs to `Salida` and `Acarreo`. `Cero` follows `Salida` in the same cycle.
- `Acarreo` is valid for exactly the cycle after the operation that produced it. It is overwritten by the next enabled operation and held while `Habilitar == 0`.
- Reset is honoured even when `Habilitar == 0`, and it cancels any operation sampled on the same edge.
- Reset mid-count or mid-shift: the next edge with `Reiniciar == 1` resumes from `VALOR_REINICIO`. No partial state survives.
- `Modo`, `Dato` and `EntSerie` must be stable only around the rising edge. Values between edges are ignored.
- Out-of-range widths are not supported: behaviour for `ANCHO < 2` is undefined.

## Configuration
- `REGISTRO_CUENTA_EN` controls the counting modes.
- Defined: modes `110` and `111` count as specified above.
- Undefined: no adder or subtractor is synthesised. Modes `110` and `111` behave exactly as hold (`000`): S unchanged, `Acarreo <= 0`.
- The shift, rotate, load and reset behaviour is identical in both builds.

## Test plan
All scenarios use `ANCHO = 4` and `VALOR_REINICIO = 0`.
- Reset: drive `Reiniciar = 0` for 1 edge with `Habilitar = 1`, `Modo = 001`, `Dato = 4'hA` -> `Salida = 0`, `Acarreo = 0`, `Cero = 1`.
- Load and hold: load `4'hA`, then set `Habilitar = 0` and `Modo = 110` for 3 edges -> `Salida` stays `4'hA`.
- Shift: load `4'b1001`, shift left with `EntSerie = 0` -> `4'b0010` with `Acarreo = 1`. Then shift right with `EntSerie = 1` -> `4'b1001` with `Acarreo = 0`.
- Rotate: load `4'b1000`, then rotate left 4 times -> `0001`, `0010`, `0100`, `1000`, with `Acarreo` = 1, 0, 0, 0.
- Count wrap (`REGISTRO_CUENTA_EN` defined): load `4'hE`, count up 3 edges -> `F`, `0`, `1`, with `Acarreo` = 0, 1, 0. Then count down 2 edges -> `0`, `F`, with `Acarreo` = 0, 1. With the macro undefined, the same stimulus leaves `Salida = 4'hE` and `Acarreo = 0`.
- Reset mid-count: during count-up at `4'h5`, assert `Reiniciar = 0` for 1 edge -> `Salida = 0`. The next enabled count edge gives `4'h1`.

Source files
------------

// File: rtl/registro_universal_n.sv
// Parametrised universal register: hold, load, shift, rotate and (optionally) up/down count.
// Define REGISTRO_CUENTA_EN to build the counting modes; otherwise modes 110/111 act as hold.
module registro_universal_n #(
   parameter int               ANCHO          = 4,
   parameter logic [ANCHO-1:0] VALOR_REINICIO = '0
) (
   input  logic             Reloj,
   input  logic             Reiniciar,
   input  logic             Habilitar,
   input  logic [2:0]       Modo,
   input  logic [ANCHO-1:0] Dato,
   input  logic             EntSerie,
   output logic [ANCHO-1:0] Salida,
   output logic             Acarreo,
   output logic             Cero
);

   typedef enum logic [2:0] {
      MODO_MANTENER = 3'b000,
      MODO_CARGAR   = 3'b001,
      MODO_DESP_IZQ = 3'b010,
      MODO_DESP_DER = 3'b011,
      MODO_ROT_IZQ  = 3'b100,
      MODO_ROT_DER  = 3'b101,
      MODO_CONT_ASC = 3'b110,
      MODO_CONT_DES = 3'b111
   } modo_t;

   logic [ANCHO-1:0] siguiente;
   logic             acarreo_sig;

`ifdef REGISTRO_CUENTA_EN
   // One extra bit so the carry out / borrow appears as the top bit.
   logic [ANCHO:0] suma;
   logic [ANCHO:0] resta;
   assign suma  = {1'b0, Salida} + {{ANCHO{1'b0}}, 1'b1};
   assign resta = {1'b0, Salida} - {{ANCHO{1'b0}}, 1'b1};
`endif

   always_comb begin
      siguiente   = Salida;
      acarreo_sig = 1'b0;
      case (modo_t'(Modo))
         MODO_MANTENER: begin
            siguiente   = Salida;
            acarreo_sig = 1'b0;
         end
         MODO_CARGAR: begin
            siguiente   = Dato;
            acarreo_sig = 1'b0;
         end
         MODO_DESP_IZQ: begin
            siguiente   = {Salida[ANCHO-2:0], EntSerie};
            acarreo_sig = Salida[ANCHO-1];
         end
         MODO_DESP_DER: begin
            siguiente   = {EntSerie, Salida[ANCHO-1:1]};
            acarreo_sig = Salida[0];
         end
         MODO_ROT_IZQ: begin
            siguiente   = {Salida[ANCHO-2:0], Salida[ANCHO-1]};
            acarreo_sig = Salida[ANCHO-1];
         end
         MODO_ROT_DER: begin
            siguiente   = {Salida[0], Salida[ANCHO-1:1]};
            acarreo_sig = Salida[0];
         end
`ifdef REGISTRO_CUENTA_EN
         MODO_CONT_ASC: begin
            siguiente   = suma[ANCHO-1:0];
            acarreo_sig = suma[ANCHO];
         end
         MODO_CONT_DES: begin
            siguiente   = resta[ANCHO-1:0];
            acarreo_sig = resta[ANCHO];
         end
`else
         MODO_CONT_ASC, MODO_CONT_DES: begin
            siguiente   = Salida;
            acarreo_sig = 1'b0;
         end
`endif
         default: begin
            siguiente   = Salida;
            acarreo_sig = 1'b0;
         end
      endcase
   end

   // Reset wins over enable; a disabled edge keeps both the word and the flag.
   always_ff @(posedge Reloj) begin
      if (!Reiniciar) begin
         Salida  <= VALOR_REINICIO;
         Acarreo <= 1'b0;
      end else if (Habilitar) begin
         Salida  <= siguiente;
         Acarreo <= acarreo_sig;
      end
   end

   assign Cero = (Salida == '0);

endmodule

// File: tb/tb_registro_universal_n.sv
// Bench for registro_universal_n (ANCHO = 4): arithmetic reference model with an
// expected queue checked every cycle, plus directed literal checks.
module tb_registro_universal_n;

   localparam int W    = 4;
   localparam int MASK = (1 << W) - 1;

   logic         Reloj;
   logic         Reiniciar;
   logic         Habilitar;
   logic [2:0]   Modo;
   logic [W-1:0] Dato;
   logic         EntSerie;
   logic [W-1:0] Salida;
   logic         Acarreo;
   logic         Cero;

   int n_compared;
   int n_mismatched;

   // Expected {Cero, Acarreo, Salida} after each driven edge.
   logic [W+1:0] exp_q[$];

   int m_s;
   int m_c;

   registro_universal_n #(.ANCHO(W), .VALOR_REINICIO(4'h0)) dut (
      .Reloj     (Reloj),
      .Reiniciar (Reiniciar),
      .Habilitar (Habilitar),
      .Modo      (Modo),
      .Dato      (Dato),
      .EntSerie  (EntSerie),
      .Salida    (Salida),
      .Acarreo   (Acarreo),
      .Cero      (Cero)
   );

   // clock / reset
   initial begin
      Reloj = 1'b0;
      forever #5 Reloj = ~Reloj;
   end

   initial begin
      Reiniciar = 1'b0;
      Habilitar = 1'b0;
      Modo      = 3'b000;
      Dato      = '0;
      EntSerie  = 1'b0;
   end

   // Reference model, written straight from the operation table with integer arithmetic.
   function automatic void model_step(input int rst, input int en, input int modo,
                                      input int dato, input int es);
      int msb;
      int lsb;
      msb = (m_s >> (W - 1)) & 1;
      lsb = m_s & 1;
      if (rst == 0) begin
         m_s = 0;
         m_c = 0;
      end else if (en != 0) begin
         case (modo)
            0: m_c = 0;
            1: begin m_s = dato & MASK; m_c = 0; end
            2: begin m_c = msb; m_s = ((m_s << 1) | es) & MASK; end
            3: begin m_c = lsb; m_s = (m_s >> 1) | (es << (W - 1)); end
            4: begin m_c = msb; m_s = ((m_s << 1) | msb) & MASK; end
            5: begin m_c = lsb; m_s = (m_s >> 1) | (lsb << (W - 1)); end
`ifdef REGISTRO_CUENTA_EN
            6: begin m_c = (m_s + 1 > MASK) ? 1 : 0; m_s = (m_s + 1) & MASK; end
            7: begin m_c = (m_s == 0) ? 1 : 0; m_s = (m_s - 1) & MASK; end
`else
            6, 7: m_c = 0;
`endif
            default: m_c = 0;
         endcase
      end
   endfunction

   // driver: apply one edge's inputs, record the model's expectation, wait past the check
   task automatic step(input logic rst, input logic en, input logic [2:0] modo,
                       input logic [W-1:0] dato, input logic es);
      logic [W-1:0] s_v;
      logic         c_v;
      logic         z_v;
      @(negedge Reloj);
      Reiniciar = rst;
      Habilitar = en;
      Modo      = modo;
      Dato      = dato;
      EntSerie  = es;
      model_step(int'(rst), int'(en), int'(modo), int'(dato), int'(es));
      s_v = m_s[W-1:0];
      c_v = (m_c != 0);
      z_v = (m_s == 0);
      exp_q.push_back({z_v, c_v, s_v});
      @(posedge Reloj);
      #2;
   endtask

   task automatic chk_lit(input string name, input logic [W-1:0] es, input logic ec);
      logic ez;
      ez = (es == '0);
      n_compared++;
      if (Salida !== es || Acarreo !== ec || Cero !== ez) begin
         n_mismatched++;
         $display("FAIL %s: got Salida=%h Acarreo=%b Cero=%b, want Salida=%h Acarreo=%b Cero=%b",
                  name, Salida, Acarreo, Cero, es, ec, ez);
      end
   endtask

   // scoreboard: every driven edge is checked against the model
   always @(posedge Reloj) begin
      logic [W+1:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_compared++;
         if ({Cero, Acarreo, Salida} !== e) begin
            n_mismatched++;
            $display("FAIL model @%0t: got Cero=%b Acarreo=%b Salida=%h, want Cero=%b Acarreo=%b Salida=%h",
                     $time, Cero, Acarreo, Salida, e[W+1], e[W], e[W-1:0]);
         end
      end
   end

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      m_s = 0;
      m_c = 0;

      // Reset beats a load sampled on the same edge.
      step(1'b0, 1'b1, 3'b001, 4'hA, 1'b0);
      chk_lit("reset", 4'h0, 1'b0);

      // Load then hold with enable low (count mode ignored).
      step(1'b1, 1'b1, 3'b001, 4'hA, 1'b0);
      chk_lit("load_a", 4'hA, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'b110, 4'h3, 1'b1);
      chk_lit("hold_disabled", 4'hA, 1'b0);

      // Shift left then right.
      step(1'b1, 1'b1, 3'b001, 4'b1001, 1'b0);
      step(1'b1, 1'b1, 3'b010, 4'h0, 1'b0);
      chk_lit("shl", 4'b0010, 1'b1);
      step(1'b1, 1'b1, 3'b011, 4'h0, 1'b1);
      chk_lit("shr", 4'b1001, 1'b0);

      // Rotate left four times.
      step(1'b1, 1'b1, 3'b001, 4'b1000, 1'b0);
      step(1'b1, 1'b1, 3'b100, 4'h0, 1'b0);
      chk_lit("rotl1", 4'b0001, 1'b1);
      step(1'b1, 1'b1, 3'b100, 4'h0, 1'b1);
      chk_lit("rotl2", 4'b0010, 1'b0);
      step(1'b1, 1'b1, 3'b100, 4'h0, 1'b0);
      chk_lit("rotl3", 4'b0100, 1'b0);
      step(1'b1, 1'b1, 3'b100, 4'h0, 1'b0);
      chk_lit("rotl4", 4'b1000, 1'b0);

      // Rotate right; flag held while disabled, cleared by hold mode.
      step(1'b1, 1'b1, 3'b001, 4'b0001, 1'b0);
      step(1'b1, 1'b1, 3'b101, 4'h0, 1'b0);
      chk_lit("rotr", 4'b1000, 1'b1);
      step(1'b1, 1'b0, 3'b011, 4'h0, 1'b0);
      chk_lit("flag_held", 4'b1000, 1'b1);
      step(1'b1, 1'b1, 3'b000, 4'h0, 1'b1);
      chk_lit("hold_clears", 4'b1000, 1'b0);

      // Count wrap up and down.
      step(1'b1, 1'b1, 3'b001, 4'hE, 1'b0);
`ifdef REGISTRO_CUENTA_EN
      step(1'b1, 1'b1, 3'b110, 4'h0, 1'b0);
      chk_lit("up1", 4'hF, 1'b0);
      step(1'b1, 1'b1, 3'b110, 4'h0, 1'b0);
      chk_lit("up2", 4'h0, 1'b1);
      step(1'b1, 1'b1, 3'b110, 4'h0, 1'b0);
      chk_lit("up3", 4'h1, 1'b0);
      step(1'b1, 1'b1, 3'b111, 4'h0, 1'b0);
      chk_lit("dn1", 4'h0, 1'b0);
      step(1'b1, 1'b1, 3'b111, 4'h0, 1'b0);
      chk_lit("dn2", 4'hF, 1'b1);
`else
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'b110, 4'h0, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 3'b111, 4'h0, 1'b0);
      chk_lit("count_off", 4'hE, 1'b0);
`endif

      // Reset in the middle of counting, then resume.
      step(1'b1, 1'b1, 3'b001, 4'h4, 1'b0);
      step(1'b1, 1'b1, 3'b110, 4'h0, 1'b0);
`ifdef REGISTRO_CUENTA_EN
      chk_lit("up_to_5", 4'h5, 1'b0);
`else
      chk_lit("up_off", 4'h4, 1'b0);
`endif
      step(1'b0, 1'b0, 3'b110, 4'h0, 1'b0);
      chk_lit("reset_mid", 4'h0, 1'b0);
      step(1'b1, 1'b1, 3'b110, 4'h0, 1'b0);
`ifdef REGISTRO_CUENTA_EN
      chk_lit("resume", 4'h1, 1'b0);
`else
      chk_lit("resume_off", 4'h0, 1'b0);
`endif

      // A short mixed run checked only by the model.
      step(1'b1, 1'b1, 3'b001, 4'h6, 1'b0);
      step(1'b1, 1'b1, 3'b011, 4'h0, 1'b1);
      step(1'b1, 1'b1, 3'b010, 4'h0, 1'b1);
      step(1'b1, 1'b1, 3'b111, 4'h0, 1'b0);
      step(1'b1, 1'b1, 3'b101, 4'h0, 1'b0);
      step(1'b1, 1'b1, 3'b100, 4'h0, 1'b0);

      @(negedge Reloj);
      if (exp_q.size() != 0) begin
         n_compared++;
         n_mismatched++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
